// File: rtl/cordic_vec_iter_if.sv
`default_nettype none
// ============================================================================
// cordic_vec_iter_if : start/done request and result bundle for cordic_vec_iter
// Rev 1.0
// ============================================================================
interface cordic_vec_iter_if #(
  parameter int gp_xy_width = 24,
  parameter int gp_z_width  = 16
);
  logic                          i_ena;
  logic                          i_start;
  logic signed [gp_xy_width-1:0] i_x;
  logic signed [gp_xy_width-1:0] i_y;
  logic        [gp_xy_width+1:0] o_mag;
  logic signed [gp_z_width-1:0]  o_phase;
  logic                          o_busy;
  logic                          o_done;

  modport master (
    output i_ena, i_start, i_x, i_y,
    input  o_mag, o_phase, o_busy, o_done
  );

  modport slave (
    input  i_ena, i_start, i_x, i_y,
    output o_mag, o_phase, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/cordic_vec_iter.sv
`default_nettype none
// ============================================================================
// cordic_vec_iter : iterative vectoring CORDIC, (x, y) -> magnitude (gain K
//                   uncompensated) and atan2 phase as a signed binary angle
// Rev 1.0
// ============================================================================
module cordic_vec_iter #(
  parameter int gp_nr_iter  = 12,
  parameter int gp_xy_width = 24,
  parameter int gp_z_width  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_an,
  cordic_vec_iter_if.slave bus
);
  localparam int                    c_xw   = gp_xy_width + 2;
  localparam logic [3:0]            c_last = 4'(gp_nr_iter - 1);
  localparam logic [gp_z_width-1:0] c_half = {1'b1, {(gp_z_width-1){1'b0}}};
  localparam int                    c_zsh  = (gp_z_width < 32) ? 32 - gp_z_width : 0;
  localparam int                    c_zup  = (gp_z_width > 32) ? gp_z_width - 32 : 0;
  localparam logic [63:0]           c_rnd  = (64'd1 << c_zsh) >> 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Base table is atan(2^-i) scaled so that 2^31 == pi, rescaled with rounding.
  function automatic logic [gp_z_width-1:0] atan_rom(input logic [3:0] idx);
    logic [63:0] b;
    b = '0;
    case (idx)
      4'd0:  b = 64'h2000_0000;
      4'd1:  b = 64'h12E4_051E;
      4'd2:  b = 64'h09FB_385B;
      4'd3:  b = 64'h0511_11D4;
      4'd4:  b = 64'h028B_0D43;
      4'd5:  b = 64'h0145_D7E1;
      4'd6:  b = 64'h00A2_F61E;
      4'd7:  b = 64'h0051_7C55;
      4'd8:  b = 64'h0028_BE53;
      4'd9:  b = 64'h0014_5F2F;
      4'd10: b = 64'h000A_2F98;
      4'd11: b = 64'h0005_17CC;
      4'd12: b = 64'h0002_8BE6;
      4'd13: b = 64'h0001_45F3;
      4'd14: b = 64'h0000_A2FA;
      4'd15: b = 64'h0000_517D;
      default: b = '0;
    endcase
    return gp_z_width'(((b + c_rnd) >> c_zsh) << c_zup);
  endfunction

  state_t                   r_state;
  state_t                   w_next;
  logic signed [c_xw-1:0]   r_x;
  logic signed [c_xw-1:0]   r_y;
  logic [gp_z_width-1:0]    r_z;
  logic [3:0]               r_iter;
  logic                     r_zero;
  logic                     r_busy;
  logic                     r_done;
  logic [c_xw-1:0]          r_mag;
  logic [gp_z_width-1:0]    r_phase;
  logic signed [c_xw-1:0]   w_x_in;
  logic signed [c_xw-1:0]   w_y_in;
  logic signed [c_xw-1:0]   w_xs;
  logic signed [c_xw-1:0]   w_ys;
  logic [gp_z_width-1:0]    w_atan;

  assign w_x_in = {{2{bus.i_x[gp_xy_width-1]}}, bus.i_x};
  assign w_y_in = {{2{bus.i_y[gp_xy_width-1]}}, bus.i_y};
  assign w_xs   = r_x >>> r_iter;
  assign w_ys   = r_y >>> r_iter;
  assign w_atan = atan_rom(r_iter);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_next = S_ITER;
      S_ITER:  if (r_iter == c_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_iter  <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mag   <= '0;
      r_phase <= '0;
    end else if (bus.i_ena) begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            // Left half-plane is folded onto the right half by a pi pre-rotation.
            if (bus.i_x[gp_xy_width-1]) begin
              r_x <= -w_x_in;
              r_y <= -w_y_in;
              r_z <= c_half;
            end else begin
              r_x <= w_x_in;
              r_y <= w_y_in;
              r_z <= '0;
            end
            r_iter <= '0;
            r_zero <= (bus.i_x == '0) && (bus.i_y == '0);
            r_busy <= 1'b1;
          end
        end
        S_ITER: begin
          if (!r_y[c_xw-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end
          r_iter <= r_iter + 4'd1;
        end
        S_DONE: begin
          r_mag   <= r_zero ? '0 : $unsigned(r_x);
          r_phase <= r_zero ? '0 : r_z;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_mag   = r_mag;
  assign bus.o_phase = r_phase;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_cordic_vec_iter.sv
`default_nettype none
// ============================================================================
// tb_cordic_vec_iter : scoreboard bench for the vectoring CORDIC (real-valued model)
// Rev 1.0
// ============================================================================
module tb_cordic_vec_iter;
  localparam int  NI = 12;
  localparam int  XW = 24;
  localparam int  ZW = 16;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    real mag;
    int  ph;
    bit  zero;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_an = 1'b0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  real  k_gain;
  exp_t sb[$];

  cordic_vec_iter_if #(.gp_xy_width(XW), .gp_z_width(ZW)) bus ();

  cordic_vec_iter #(
    .gp_nr_iter (NI),
    .gp_xy_width(XW),
    .gp_z_width (ZW)
  ) dut (
    .i_clk   (clk),
    .i_rst_an(rst_an),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called on a falling edge with the DUT idle; returns the cycle stamp of the accepting edge.
  task automatic launch(input int x, input int y, output int acc);
    exp_t e;
    real  a;
    bus.i_x     = XW'(x);
    bus.i_y     = XW'(y);
    bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    acc = cyc;
    e.zero = (x == 0) && (y == 0);
    if (e.zero) begin
      e.mag = 0.0;
      e.ph  = 0;
    end else begin
      e.mag = k_gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      a     = $atan2(real'(y), real'(x)) * 32768.0 / PI;
      e.ph  = int'(a);
    end
    sb.push_back(e);
  endtask

  task automatic wait_done(output int at, output bit to);
    to = 1'b1;
    at = cyc;
    for (int i = 0; i < 200; i++) begin
      if (bus.o_done === 1'b1) begin
        at = cyc;
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (bus.o_mag !== '0) begin n_fail++; $display("FAIL reset_mag: got %0d want 0", bus.o_mag); end
    n_chk++; if (bus.o_phase !== '0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", bus.o_phase); end
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    n_chk++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    rst_an = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    int vx[7] = '{4194304, 0, -4194304, -2097152, 2097152, 0, -8388608};
    int vy[7] = '{0, 4194304, 0, -2097152, 2097152, 0, -8388608};
    int acc, dn, ph_tol;
    bit to;
    exp_t e;
    real mg, dm, mtol;
    logic signed [15:0] dph;
    for (int i = 0; i < 7; i++) begin
      launch(vx[i], vy[i], acc);
      wait_done(dn, to);
      e      = sb.pop_front();
      ph_tol = e.zero ? 0 : 4;
      mtol   = e.zero ? 0.0 : 0.0005 * e.mag + 4.0;
      mg     = real'(int'(bus.o_mag));
      dm     = (mg > e.mag) ? mg - e.mag : e.mag - mg;
      dph    = 16'(int'(bus.o_phase) - e.ph);
      n_chk++; if (to || (dn - acc) != NI + 1) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want %0d timeout=%0b", i, dn - acc, NI + 1, to); end
      n_chk++; if (dm > mtol) begin n_fail++; $display("FAIL vec%0d_mag: got %0d want %f", i, bus.o_mag, e.mag); end
      n_chk++; if (int'(dph) > ph_tol || int'(dph) < -ph_tol) begin n_fail++; $display("FAIL vec%0d_phase: got %0d want %0d", i, bus.o_phase, e.ph); end
      n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL vec%0d_busy_at_done: got %b want 0", i, bus.o_busy); end
      @(negedge clk);
      n_chk++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL vec%0d_done_pulse: got %b want 0", i, bus.o_done); end
    end
  endtask

  // Start is held through the whole ITER phase but dropped before the done cycle.
  task automatic test_handshake();
    int n_busy = 0, n_done = 0, acc = 0, dn = -1;
    bus.i_x     = XW'(2097152);
    bus.i_y     = XW'(2097152);
    bus.i_start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) acc = cyc;
      if (bus.o_busy === 1'b1) n_busy++;
      if (bus.o_done === 1'b1) begin n_done++; dn = cyc; end
    end
    bus.i_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b1) n_busy++;
      if (bus.o_done === 1'b1) begin n_done++; dn = cyc; end
    end
    n_chk++; if (n_busy != NI + 1) begin n_fail++; $display("FAIL hs_busy_cycles: got %0d want %0d", n_busy, NI + 1); end
    n_chk++; if (n_done != 1) begin n_fail++; $display("FAIL hs_done_pulses: got %0d want 1", n_done); end
    n_chk++; if (dn - acc != NI + 1) begin n_fail++; $display("FAIL hs_latency: got %0d want %0d", dn - acc, NI + 1); end
  endtask

  task automatic test_back_to_back();
    int acc_a, dn_a, acc_b, dn_b;
    bit to;
    exp_t e;
    logic signed [15:0] dph;
    launch(0, 4194304, acc_a);
    wait_done(dn_a, to);
    e   = sb.pop_front();
    dph = 16'(int'(bus.o_phase) - e.ph);
    n_chk++; if (to || int'(dph) > 4 || int'(dph) < -4) begin n_fail++; $display("FAIL b2b_first_phase: got %0d want %0d timeout=%0b", bus.o_phase, e.ph, to); end
    launch(2097152, 2097152, acc_b);
    wait_done(dn_b, to);
    e   = sb.pop_front();
    dph = 16'(int'(bus.o_phase) - e.ph);
    n_chk++; if (to || (dn_b - dn_a) != NI + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d timeout=%0b", dn_b - dn_a, NI + 2, to); end
    n_chk++; if (int'(dph) > 4 || int'(dph) < -4) begin n_fail++; $display("FAIL b2b_second_phase: got %0d want %0d", bus.o_phase, e.ph); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int acc, dn;
    bit to;
    exp_t e;
    real mg, dm;
    logic signed [15:0] dph;
    launch(4194304, 0, acc);
    repeat (4) @(negedge clk);
    bus.i_ena = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b want 1", bus.o_busy); end
    bus.i_ena = 1'b1;
    wait_done(dn, to);
    e   = sb.pop_front();
    mg  = real'(int'(bus.o_mag));
    dm  = (mg > e.mag) ? mg - e.mag : e.mag - mg;
    dph = 16'(int'(bus.o_phase) - e.ph);
    n_chk++; if (to || (dn - acc) != NI + 1 + 5) begin n_fail++; $display("FAIL stall_latency: got %0d want %0d timeout=%0b", dn - acc, NI + 6, to); end
    n_chk++; if (dm > 0.0005 * e.mag + 4.0) begin n_fail++; $display("FAIL stall_mag: got %0d want %f", bus.o_mag, e.mag); end
    n_chk++; if (int'(dph) > 4 || int'(dph) < -4) begin n_fail++; $display("FAIL stall_phase: got %0d want %0d", bus.o_phase, e.ph); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int acc, dn, n_done = 0;
    bit to;
    exp_t e;
    logic signed [15:0] dph;
    launch(-2097152, -2097152, acc);
    repeat (5) @(negedge clk);
    rst_an = 1'b0;
    #1;
    n_chk++; if (bus.o_mag !== '0) begin n_fail++; $display("FAIL rstmid_mag: got %0d want 0", bus.o_mag); end
    n_chk++; if (bus.o_phase !== '0) begin n_fail++; $display("FAIL rstmid_phase: got %0d want 0", bus.o_phase); end
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.o_busy); end
    void'(sb.pop_back());
    @(negedge clk);
    rst_an = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) n_done++;
    end
    n_chk++; if (n_done != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", n_done); end
    launch(-2097152, -2097152, acc);
    wait_done(dn, to);
    e   = sb.pop_front();
    dph = 16'(int'(bus.o_phase) - e.ph);
    n_chk++; if (to || (dn - acc) != NI + 1) begin n_fail++; $display("FAIL rstmid_after_latency: got %0d want %0d timeout=%0b", dn - acc, NI + 1, to); end
    n_chk++; if (int'(dph) > 4 || int'(dph) < -4) begin n_fail++; $display("FAIL rstmid_after_phase: got %0d want %0d", bus.o_phase, e.ph); end
  endtask

  initial begin
    real p;
    k_gain = 1.0;
    p      = 1.0;
    for (int i = 0; i < NI; i++) begin
      k_gain = k_gain * $sqrt(1.0 + p);
      p      = p / 4.0;
    end
    bus.i_ena   = 1'b1;
    bus.i_start = 1'b0;
    bus.i_x     = '0;
    bus.i_y     = '0;
    test_reset();
    test_vectors();
    test_handshake();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_chk);
    $fatal(1);
  end
endmodule
`default_nettype wire
